stream_frame_fifo: RTL
======================

# stream_frame_fifo

Synthesizable stencil-stream buffer between the stream source and the accelerator input port. It accepts stencil beats (tdata/tvalid/tlast/tready) and buffers them in a DEPTH-entry FIFO. It checks that the source's tlast lands exactly on the last beat of each frame. It presents the accelerator with a regenerated, guaranteed-correct tlast plus frame-completion status.

## Interface
Parameters:
- IMG_EXTENT_0..3, defaults 256, 256, 1, 1: image extents per dimension.
- ST_EXTENT_0..3, defaults 1, 1, 1, 1: stencil extents per dimension. Each IMG_EXTENT_n is an exact multiple of ST_EXTENT_n.
- DATA_SIZE, default 8: bits per pixel.
- DEPTH, default 16: FIFO entries. Power of two, at least 2.
- Derived values, not overridable:
  - DATA_W = DATA_SIZE*ST_EXTENT_0*ST_EXTENT_1*ST_EXTENT_2*ST_EXTENT_3.
  - BEATS = product over n of (IMG_EXTENT_n/ST_EXTENT_n).

Ports:
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- in_tdata, in, DATA_W: flattened stencil. Element [s3][s2][s1][s0] occupies bits at offset DATA_SIZE*(((s3*ST2+s2)*ST1+s1)*ST0+s0).
- in_tvalid, in, 1: source beat valid.
- in_tlast, in, 1: source end-of-frame marker.
- in_tready, out, 1: block can accept a beat.
- out_tdata, out, DATA_W: FIFO head data.
- out_tvalid, out, 1: FIFO not empty.
- out_tlast, out, 1: regenerated end-of-frame for the head beat.
- out_tready, in, 1: consumer accepts the beat.
- frame_done, out, 1: one-cycle pulse after the last beat of a frame leaves.
- frames_out, out, 16: completed-frame counter; wraps modulo 2^16.
- err_tlast, out, 1: sticky tlast-mismatch flag.
- err_beat, out, 32: input beat index of the first mismatch.
- level, out, $clog2(DEPTH)+1: current occupancy.

## Operation
- Push happens when in_tvalid && in_tready. Pop happens when out_tvalid && out_tready.
- Input beat counter `ibeat`:
  - Range 0..BEATS-1. Increments on push and wraps to 0 after BEATS-1.
  - exp_last = (ibeat == BEATS-1).
  - The FIFO stores {exp_last, in_tdata}.
  - out_tlast is the stored exp_last, never the raw in_tlast.
- Mismatch check:
  - On a push with in_tlast != exp_last, the first occurrence sets err_tlast and captures ibeat into err_beat.
  - Later mismatches change neither output.
  - Both clear only on reset.
  - Data is never dropped or altered on a mismatch.
- Pop of an entry with stored last = 1: the next cycle has frame_done = 1, and frames_out increments on the same edge.
- in_tready = (level < DEPTH), computed from registered level only. There is no combinational path from out_tready. When full, a pop in the same cycle does not enable a push.
- Simultaneous push and pop when 0 < level < DEPTH: level is unchanged, and both pointers advance.
- Push when level == 0: the beat appears at out_* on the next cycle. There is no bypass.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by level, not pointer equality.

## Timing
- Reset values:
  - in_tready 1 after reset deasserts; 0 while reset_n = 0.
  - out_tvalid 0, out_tlast 0, out_tdata 0.
  - frame_done 0, frames_out 0.
  - err_tlast 0, err_beat 0, level 0.
  - ibeat 0, read/write pointers 0.
- Reset asserted mid-frame discards all FIFO contents and resets ibeat. The first beat after reset is beat 0 of a new frame.
- Latency from input handshake to out_tvalid: 1 cycle.
- Throughput: 1 beat/cycle sustained when 0 < level < DEPTH.
- out_tdata and out_tlast hold stable while out_tvalid && !out_tready.
- frame_done: exactly 1 cycle, registered, 1 cycle after the tlast pop.
- err_tlast and err_beat update 1 cycle after the offending push.

## Structure
- Shared package `stream_pkg`:
  - Function computing BEATS from the extents.
  - Function computing DATA_W.
  - Stencil flatten/unflatten index function (s3, s2, s1, s0 → bit offset), reused by the source/sink models and the accelerator wrappers.
- Sub-module `stream_fifo_mem`: DEPTH x (DATA_W+1) storage, one write port, one read port, registered read-pointer addressing.
- Top level holds pointers, level, ibeat, frame and error logic.

## Test plan
Configuration: IMG 8x4x1x1, ST 2x1x1x1 (BEATS = 16), DEPTH = 4, DATA_SIZE = 8.
- Reset then idle → in_tready = 1, out_tvalid = 0, level = 0, frames_out = 0, err_tlast = 0.
- One frame of 16 beats with data 0..15 and correct tlast on beat 15, out_tready held 1:
  - out_tdata sequence is 0..15, each 1 cycle after its push.
  - out_tlast = 1 only on beat 15.
  - frame_done pulses once; frames_out = 1.
- out_tready = 0 while pushing 5 beats:
  - level reaches 4; in_tready = 0 after the 4th beat; the 5th is held by the source.
  - Raise out_tready: data emerges in order with no loss.
- Source asserts tlast on beat 7 of 16:
  - err_tlast = 1, err_beat = 7.
  - out_tlast asserted only on beat 15.
  - A second bad tlast on beat 9 leaves err_beat = 7.
- Assert reset_n = 0 after 6 beats of a frame with level = 3:
  - All outputs return to reset values.
  - The next 16-beat frame completes with out_tlast on its 16th beat and frames_out = 1.
- Random out_tready (50%) with a continuous source over 3 frames:
  - Output matches input order exactly.
  - frames_out = 3; err_tlast = 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared helpers for stencil streams: frame length, flattened stencil width
// and the bit offset of one stencil element inside a flattened beat.
package stream_pkg;

    localparam int FRAMES_W   = 16;
    localparam int ERR_BEAT_W = 32;

    function automatic int calc_beats(input int img0, input int img1, input int img2, input int img3,
                                      input int st0, input int st1, input int st2, input int st3);
        return (img0 / st0) * (img1 / st1) * (img2 / st2) * (img3 / st3);
    endfunction

    function automatic int calc_data_w(input int data_size, input int st0, input int st1,
                                       input int st2, input int st3);
        return data_size * st0 * st1 * st2 * st3;
    endfunction

    // Element [s3][s2][s1][s0] of a flattened stencil, s0 fastest-varying.
    function automatic int stencil_offset(input int data_size, input int st0, input int st1,
                                          input int st2, input int s3, input int s2,
                                          input int s1, input int s0);
        return data_size * (((s3 * st2 + s2) * st1 + s1) * st0 + s0);
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// FIFO storage: one synchronous write port, asynchronous read addressed by
// the registered read pointer of the owner.
module stream_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_frame_fifo.sv
// Frame-aware stencil FIFO: buffers beats, regenerates tlast from a beat
// counter, flags the first misplaced source tlast and counts finished frames.
module stream_frame_fifo
    import stream_pkg::*;
#(
    parameter int IMG_EXTENT_0 = 256,
    parameter int IMG_EXTENT_1 = 256,
    parameter int IMG_EXTENT_2 = 1,
    parameter int IMG_EXTENT_3 = 1,
    parameter int ST_EXTENT_0  = 1,
    parameter int ST_EXTENT_1  = 1,
    parameter int ST_EXTENT_2  = 1,
    parameter int ST_EXTENT_3  = 1,
    parameter int DATA_SIZE    = 8,
    parameter int DEPTH        = 16,
    localparam int DATA_W = calc_data_w(DATA_SIZE, ST_EXTENT_0, ST_EXTENT_1, ST_EXTENT_2, ST_EXTENT_3),
    localparam int BEATS  = calc_beats(IMG_EXTENT_0, IMG_EXTENT_1, IMG_EXTENT_2, IMG_EXTENT_3,
                                       ST_EXTENT_0, ST_EXTENT_1, ST_EXTENT_2, ST_EXTENT_3),
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     in_tdata,
    input  logic                  in_tvalid,
    input  logic                  in_tlast,
    output logic                  in_tready,
    output logic [DATA_W-1:0]     out_tdata,
    output logic                  out_tvalid,
    output logic                  out_tlast,
    input  logic                  out_tready,
    output logic                  frame_done,
    output logic [FRAMES_W-1:0]   frames_out,
    output logic                  err_tlast,
    output logic [ERR_BEAT_W-1:0] err_beat,
    output logic [LVL_W-1:0]      level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0]      FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [ERR_BEAT_W-1:0] LAST_BEAT = ERR_BEAT_W'(BEATS - 1);

    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [LVL_W-1:0]      r_level;
    logic [ERR_BEAT_W-1:0] r_ibeat;
    logic                  r_frame_done;
    logic [FRAMES_W-1:0]   r_frames_out;
    logic                  r_err_tlast;
    logic [ERR_BEAT_W-1:0] r_err_beat;

    logic                  w_ready;
    logic                  w_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_exp_last;
    logic                  w_head_last;
    logic [DATA_W:0]       w_rd_entry;

    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign w_ready    = reset_n && (r_level < FULL_LVL);
    assign w_valid    = (r_level != '0);
    assign w_push     = in_tvalid && w_ready;
    assign w_pop      = w_valid && out_tready;
    assign w_exp_last = (r_ibeat == LAST_BEAT);

    stream_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata ({w_exp_last, in_tdata}),
        .i_raddr (r_rptr),
        .o_rdata (w_rd_entry)
    );

    // Head outputs read as zero while empty so stale storage never leaks out.
    assign w_head_last = w_valid && w_rd_entry[DATA_W];
    assign out_tdata   = w_valid ? w_rd_entry[DATA_W-1:0] : '0;
    assign out_tlast   = w_head_last;
    assign out_tvalid  = w_valid;
    assign in_tready   = w_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ibeat <= '0;
        end else begin
            if (w_push) begin
                r_wptr  <= r_wptr + 1'b1;
                r_ibeat <= w_exp_last ? '0 : r_ibeat + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Frame completion is driven by the regenerated marker; only the first tlast error is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_done <= 1'b0;
            r_frames_out <= '0;
            r_err_tlast  <= 1'b0;
            r_err_beat   <= '0;
        end else begin
            r_frame_done <= w_pop && w_head_last;
            if (w_pop && w_head_last) begin
                r_frames_out <= r_frames_out + 1'b1;
            end
            if (w_push && (in_tlast != w_exp_last) && !r_err_tlast) begin
                r_err_tlast <= 1'b1;
                r_err_beat  <= r_ibeat;
            end
        end
    end

    assign frame_done = r_frame_done;
    assign frames_out = r_frames_out;
    assign err_tlast  = r_err_tlast;
    assign err_beat   = r_err_beat;
    assign level      = r_level;

endmodule
